bcd_updown_counter: RTL

//  Parametrised multi-digit BCD up/down counter: next generation of the fixed
//  4-digit up-only BCD counter, used for the board's decimal event/time counts.

---
 rtl/bcd_updown_counter.sv | 103 ++++++++++
 1 files changed

// File: rtl/bcd_updown_counter.sv
// Parametrised multi-digit BCD up/down counter with load, clear, compare match,
// wrap pulse and sticky overflow. Define SATURATE_EN to hold at MAX/0 instead of rolling over.
module bcd_updown_counter #(
  parameter  int DIGITS = 4,
  localparam int W      = 4 * DIGITS
) (
  input  logic         clk,
  input  logic         _reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         enable,
  input  logic         up,
  input  logic [W-1:0] match_val,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         ovr,
  output logic         match
);

  logic [W-1:0] count_q, count_d;
  logic         wrap_q, wrap_d;
  logic         ovr_q, ovr_d;
  logic [W-1:0] load_bcd;
  logic [W-1:0] step_val;
  logic         carry;

  // Clamp each loaded digit independently so no non-BCD digit is ever stored.
  always_comb begin
    load_bcd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      load_bcd[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
  end

  // One-step ripple: carry/borrow enters digit 0 and propagates while digits
  // sit at the rollover value; a carry left over at the top means max<->0 crossed.
  always_comb begin
    step_val = count_q;
    carry    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (up) begin
          if (count_q[4*i +: 4] == 4'd9) begin
            step_val[4*i +: 4] = 4'd0;
          end else begin
            step_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
            carry              = 1'b0;
          end
        end else begin
          if (count_q[4*i +: 4] == 4'd0) begin
            step_val[4*i +: 4] = 4'd9;
          end else begin
            step_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
            carry              = 1'b0;
          end
        end
      end
    end
  end

  // NOTE: every variable gets a default before any branch, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovr_d   = ovr_q;
    if (clr) begin
      count_d = '0;
      ovr_d   = 1'b0;
    end else if (load) begin
      count_d = load_bcd;
    end else if (enable) begin
`ifdef SATURATE_EN
      count_d = carry ? count_q : step_val;
`else
      count_d = step_val;
`endif
      wrap_d  = carry;
      ovr_d   = ovr_q | carry;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the async reset clears all state without waiting for clk.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovr_q   <= ovr_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign ovr   = ovr_q;
  assign match = (count_q == match_val);

endmodule
